// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, header field positions,
// output-port indices and the XY routing helper.
package noc_pkg;

  localparam int FLIT_W   = 32;
  localparam int TYPE_HI  = 31;
  localparam int TYPE_LO  = 30;
  localparam int DST_X_LO = 24;
  localparam int DST_Y_LO = 20;
  localparam int COORD_W  = 4;

  localparam int PORT_L   = 0;
  localparam int PORT_N   = 1;
  localparam int PORT_E   = 2;
  localparam int PORT_S   = 3;
  localparam int PORT_W   = 4;
  localparam int PORT_NUM = 5;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } port_state_e;

  // Dimension-ordered routing: resolve X first, then Y, else eject locally.
  function automatic logic [PORT_NUM-1:0] xy_route(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] here_x,
    input logic [COORD_W-1:0] here_y
  );
    logic [PORT_NUM-1:0] req;
    req = '0;
    if (dst_x > here_x)      req[PORT_E] = 1'b1;
    else if (dst_x < here_x) req[PORT_W] = 1'b1;
    else if (dst_y > here_y) req[PORT_N] = 1'b1;
    else if (dst_y < here_y) req[PORT_S] = 1'b1;
    else                     req[PORT_L] = 1'b1;
    return req;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// DEPTH x WIDTH synchronous FIFO with push/pop/full/empty/count.
// A push while full is accepted only if a pop happens in the same cycle.
module noc_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: flit buffer, credit return, XY route computation and
// request/transfer FSM toward the switch allocator and crossbar.
// Optional error detection is enabled by defining NOC_INPUT_PORT_ERRCHK_EN.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLIT_W-1:0]   i_flit,
  input  logic                i_flit_valid,
  output logic                o_credit,
  output logic [PORT_NUM-1:0] o_req,
  input  logic                i_grant,
  output logic [FLIT_W-1:0]   o_flit,
  output logic                o_flit_valid,
  input  logic                i_ready,
  output logic [1:0]          o_err
);

  localparam logic [COORD_W-1:0] HERE_X = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(LOCAL_Y);

  port_state_e         state_q, state_d;
  logic [PORT_NUM-1:0] route_q;
  logic                first_q;
  logic                credit_q;
  logic [FLIT_W-1:0]   head_flit;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                pop;
  logic                flit_valid;
  flit_type_e          head_type;
  logic                head_is_head;
  logic                head_is_tail;

  noc_flit_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (i_flit_valid),
    .push_data (i_flit),
    .pop       (pop),
    .head_data (head_flit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_type    = flit_type_e'(head_flit[TYPE_HI:TYPE_LO]);
  assign head_is_head = (head_type == FLIT_HEAD) || (head_type == FLIT_SINGLE);
  assign head_is_tail = (head_type == FLIT_TAIL) || (head_type == FLIT_SINGLE);

  // Next-state, pop and crossbar-valid decode; stray body/tail in IDLE is dropped.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    flit_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_is_head) state_d = ST_REQ;
          else              pop     = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_grant && (route_q != '0)) state_d = ST_XFER;
      end
      ST_XFER: begin
        flit_valid = !fifo_empty;
        if (flit_valid && i_ready) begin
          pop = 1'b1;
          if (head_is_tail) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Route is latched on REQ entry and held until the tail leaves; first_q marks the head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      route_q <= '0;
      first_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_REQ)
        route_q <= xy_route(head_flit[DST_X_LO +: COORD_W],
                            head_flit[DST_Y_LO +: COORD_W], HERE_X, HERE_Y);
      else if (state_q == ST_XFER && state_d == ST_IDLE)
        route_q <= '0;
      if (state_q == ST_REQ && state_d == ST_XFER) first_q <= 1'b1;
      else if (pop)                               first_q <= 1'b0;
    end
  end

  // One credit pulse per popped flit, one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) credit_q <= 1'b0;
    else     credit_q <= pop;
  end

  assign o_credit     = credit_q;
  assign o_req        = route_q;
  assign o_flit_valid = flit_valid;
  assign o_flit       = flit_valid ? head_flit : '0;

`ifdef NOC_INPUT_PORT_ERRCHK_EN
  logic [1:0] err_q;
  logic       overflow;
  logic       frame_idle;
  logic       frame_mid;

  assign overflow   = i_flit_valid && fifo_full && !pop;
  assign frame_idle = (state_q == ST_IDLE) && !fifo_empty && !head_is_head;
  assign frame_mid  = (state_q == ST_XFER) && !first_q && !fifo_empty && head_is_head;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_q | {frame_idle || frame_mid, overflow};
  end

  assign o_err = err_q;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at LOCAL=(1,1), DEPTH=4.
module tb_noc_input_port;
  import noc_pkg::*;

  localparam int DEPTH = 4;

`ifdef NOC_INPUT_PORT_ERRCHK_EN
  localparam logic [1:0] ERR_OV   = 2'b01;
  localparam logic [1:0] ERR_BOTH = 2'b11;
`else
  localparam logic [1:0] ERR_OV   = 2'b00;
  localparam logic [1:0] ERR_BOTH = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_flit;
  logic        i_flit_valid;
  logic        o_credit;
  logic [4:0]  o_req;
  logic        i_grant;
  logic [31:0] o_flit;
  logic        o_flit_valid;
  logic        i_ready;
  logic [1:0]  o_err;

  typedef struct packed {
    logic [31:0] flit;
    logic [4:0]  req;
  } exp_t;

  exp_t sb[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   credit_cnt = 0;
  int   c0;

  noc_input_port #(.DEPTH(DEPTH), .LOCAL_X(1), .LOCAL_Y(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flit       (i_flit),
    .i_flit_valid (i_flit_valid),
    .o_credit     (o_credit),
    .o_req        (o_req),
    .i_grant      (i_grant),
    .o_flit       (o_flit),
    .o_flit_valid (o_flit_valid),
    .i_ready      (i_ready),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic [19:0] pl);
    return {t, 2'b00, dx, dy, pl};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] flit);
    i_flit       = flit;
    i_flit_valid = 1'b1;
    tick();
    i_flit_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    checkOutput(name, sb.size(), 0);
  endtask

  // Monitor: count credits and compare each accepted crossbar flit against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_credit) credit_cnt++;
    if (!rst && o_flit_valid && i_ready) begin
      if (sb.size() == 0) begin
        assert_cnt++;
        fail_cnt++;
        $display("[TB] FAIL unexpected_flit actual=%h required=none", o_flit);
      end else begin
        e = sb.pop_front();
        checkOutput("flit_data", o_flit, e.flit);
        checkOutput("flit_req", {27'd0, o_req}, {27'd0, e.req});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] f;
    rst = 1'b1; i_flit = '0; i_flit_valid = 1'b0; i_grant = 1'b0; i_ready = 1'b1;
    tick(); tick();
    checkOutput("rst_req", {27'd0, o_req}, 32'd0);
    checkOutput("rst_credit", {31'd0, o_credit}, 32'd0);
    checkOutput("rst_valid", {31'd0, o_flit_valid}, 32'd0);
    checkOutput("rst_flit", o_flit, 32'd0);
    checkOutput("rst_err", {30'd0, o_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Single flit to (3,1): east.
    $display("[TB] single flit east");
    c0 = credit_cnt;
    f = mk(2'b11, 4'd3, 4'd1, 20'hABCDE);
    sb.push_back('{flit: f, req: 5'b00100});
    applyStimulus(f);
    checkOutput("t1_req_early", {27'd0, o_req}, 32'd0);
    tick();
    checkOutput("t1_req", {27'd0, o_req}, 32'h04);
    i_grant = 1'b1;
    tick();
    i_grant = 1'b0;
    checkOutput("t1_valid", {31'd0, o_flit_valid}, 32'd1);
    checkOutput("t1_credit_pre", {31'd0, o_credit}, 32'd0);
    tick();
    checkOutput("t1_credit_pulse", {31'd0, o_credit}, 32'd1);
    checkOutput("t1_req_clear", {27'd0, o_req}, 32'd0);
    tick();
    checkOutput("t1_credit_end", {31'd0, o_credit}, 32'd0);
    checkOutput("t1_credits", credit_cnt - c0, 32'd1);

    // Four-flit packet to (1,0): south, streamed back to back.
    $display("[TB] four flit packet south");
    c0 = credit_cnt;
    i_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f = mk((i == 0) ? 2'b10 : ((i == 3) ? 2'b01 : 2'b00), 4'd1, 4'd0, 20'h20000 + 20'(i));
      sb.push_back('{flit: f, req: 5'b01000});
      applyStimulus(f);
    end
    waitDrain("t2_drain");
    i_grant = 1'b0;
    tick(); tick();
    checkOutput("t2_credits", credit_cnt - c0, 32'd4);
    checkOutput("t2_req_clear", {27'd0, o_req}, 32'd0);

    // Overflow: fill with no pops, drop a fifth, then drain intact contents.
    $display("[TB] overflow");
    c0 = credit_cnt;
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f = mk((i == 0) ? 2'b10 : 2'b00, 4'd2, 4'd1, 20'h30000 + 20'(i));
      sb.push_back('{flit: f, req: 5'b00100});
      applyStimulus(f);
    end
    applyStimulus(mk(2'b01, 4'd2, 4'd1, 20'h3DEAD));
    tick();
    checkOutput("t3_err_ov", {30'd0, o_err}, {30'd0, ERR_OV});
    checkOutput("t3_req", {27'd0, o_req}, 32'h04);
    i_ready = 1'b1;
    i_grant = 1'b1;
    tick();
    i_grant = 1'b0;
    waitDrain("t3_drain");
    f = mk(2'b01, 4'd2, 4'd1, 20'h3FFFF);
    sb.push_back('{flit: f, req: 5'b00100});
    applyStimulus(f);
    waitDrain("t3_drain_tail");
    tick(); tick();
    checkOutput("t3_credits", credit_cnt - c0, 32'd5);
    checkOutput("t3_req_clear", {27'd0, o_req}, 32'd0);

    // Stray body flit in IDLE: discarded with a credit.
    $display("[TB] stray body");
    c0 = credit_cnt;
    applyStimulus(mk(2'b00, 4'd0, 4'd0, 20'h40000));
    tick(); tick(); tick();
    checkOutput("t4_credits", credit_cnt - c0, 32'd1);
    checkOutput("t4_err", {30'd0, o_err}, {30'd0, ERR_BOTH});
    checkOutput("t4_req", {27'd0, o_req}, 32'd0);

    // Local destination, then reset in the middle of the transfer.
    $display("[TB] local dest and mid-packet reset");
    c0 = credit_cnt;
    i_ready = 1'b0;
    applyStimulus(mk(2'b10, 4'd1, 4'd1, 20'h50000));
    applyStimulus(mk(2'b00, 4'd1, 4'd1, 20'h50001));
    checkOutput("t5_req_local", {27'd0, o_req}, 32'h01);
    i_grant = 1'b1;
    tick();
    i_grant = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_rst_req", {27'd0, o_req}, 32'd0);
    checkOutput("t5_rst_valid", {31'd0, o_flit_valid}, 32'd0);
    checkOutput("t5_rst_flit", o_flit, 32'd0);
    checkOutput("t5_rst_err", {30'd0, o_err}, 32'd0);
    i_ready = 1'b1;
    i_grant = 1'b1;
    tick(); tick(); tick();
    i_grant = 1'b0;
    checkOutput("t5_fifo_empty", {31'd0, o_flit_valid}, 32'd0);
    checkOutput("t5_req_idle", {27'd0, o_req}, 32'd0);
    checkOutput("t5_credits", credit_cnt - c0, 32'd0);

    // Full FIFO with simultaneous push and pop for 20 cycles, west.
    $display("[TB] full streaming");
    c0 = credit_cnt;
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f = mk((i == 0) ? 2'b10 : 2'b00, 4'd0, 4'd1, 20'h60000 + 20'(i));
      sb.push_back('{flit: f, req: 5'b10000});
      applyStimulus(f);
    end
    i_grant = 1'b1;
    tick();
    i_grant = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      f = mk((i == 19) ? 2'b01 : 2'b00, 4'd0, 4'd1, 20'h60004 + 20'(i));
      sb.push_back('{flit: f, req: 5'b10000});
      i_flit       = f;
      i_flit_valid = 1'b1;
      tick();
    end
    i_flit_valid = 1'b0;
    checkOutput("t6_no_overflow", {30'd0, o_err}, 32'd0);
    checkOutput("t6_streaming_credits", credit_cnt - c0, 32'd19);
    waitDrain("t6_drain");
    tick(); tick();
    checkOutput("t6_credits", credit_cnt - c0, 32'd24);
    checkOutput("t6_req_clear", {27'd0, o_req}, 32'd0);
    checkOutput("t6_err_end", {30'd0, o_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
